// File: rtl/data_sram_bridge_pkg.sv
// rtl/data_sram_bridge_pkg.sv - shared constants and state encoding for the sram-like data bridge
package data_sram_bridge_pkg;

    localparam int SRAM_WEN_W  = 4;
    localparam int SRAM_SIZE_W = 2;

    localparam logic [SRAM_SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SRAM_SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SRAM_SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/data_sram_bridge_wen_to_size.sv
// rtl/data_sram_bridge_wen_to_size.sv - byte strobe to transfer size and bus address
module data_sram_bridge_wen_to_size
    import data_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [SRAM_WEN_W-1:0]  wen,
    input  logic [ADDR_W-1:0]      addr,
    output logic [SRAM_SIZE_W-1:0] size,
    output logic [ADDR_W-1:0]      bus_addr
);

    // Single-lane and aligned-half strobes keep the byte address; everything else is a word access
    always_comb begin
        size     = SIZE_WORD;
        bus_addr = {addr[ADDR_W-1:2], 2'b00};
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                size     = SIZE_BYTE;
                bus_addr = addr;
            end
            4'b0011, 4'b1100: begin
                size     = SIZE_HALF;
                bus_addr = addr;
            end
            default: begin
                size     = SIZE_WORD;
                bus_addr = {addr[ADDR_W-1:2], 2'b00};
            end
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - MEM-stage access to single sram-like bus transaction bridge
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_en,
    input  logic [SRAM_WEN_W-1:0]  cpu_wen,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    input  logic                   cpu_flush,
    input  logic                   pipe_stall,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_stall,
    output logic                   data_req,
    output logic                   data_wr,
    output logic [SRAM_SIZE_W-1:0] data_size,
    output logic [ADDR_W-1:0]      data_addr,
    output logic [DATA_W-1:0]      data_wdata,
    input  logic                   data_addr_ok,
    input  logic                   data_data_ok,
    input  logic [DATA_W-1:0]      data_rdata
);

    state_t                  state;
    state_t                  state_nxt;
    logic                    cancel;
    logic                    latch_req;
    logic                    latch_rdata;
    logic [SRAM_SIZE_W-1:0]  req_size;
    logic [ADDR_W-1:0]       req_addr;

    data_sram_bridge_wen_to_size #(
        .ADDR_W (ADDR_W)
    ) u_wen_to_size (
        .wen      (cpu_wen),
        .addr     (cpu_addr),
        .size     (req_size),
        .bus_addr (req_addr)
    );

    // Next state, bus request and pipeline stall; stall is released as soon as reset is asserted
    always_comb begin
        state_nxt   = state;
        data_req    = 1'b0;
        cpu_stall   = 1'b0;
        latch_req   = 1'b0;
        latch_rdata = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_stall = cpu_en & ~cpu_flush;
                if (cpu_en && !cpu_flush) begin
                    latch_req = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                // data_ok cannot legally arrive before addr_ok, so it is not looked at here
                data_req  = 1'b1;
                cpu_stall = 1'b1;
                if (data_addr_ok) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                // A cancelled access no longer belongs to the instruction in MEM
                cpu_stall = ~cancel;
                if (data_data_ok) begin
                    latch_rdata = ~data_wr;
                    state_nxt   = cancel ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                if (!pipe_stall) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            cpu_stall = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Cancel flag: a flush while the request is still pending lets the bus finish but drops the result
    always_ff @(posedge clk) begin
        if (rst) begin
            cancel <= 1'b0;
        end else if (latch_req) begin
            cancel <= 1'b0;
        end else if (state == S_ADDR && cpu_flush) begin
            cancel <= 1'b1;
        end else if (state == S_DATA && data_data_ok) begin
            cancel <= 1'b0;
        end
    end

    // Request fields are captured once in IDLE and held for the whole transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            data_wr    <= 1'b0;
            data_size  <= SIZE_BYTE;
            data_addr  <= '0;
            data_wdata <= '0;
        end else if (latch_req) begin
            data_wr    <= |cpu_wen;
            data_size  <= req_size;
            data_addr  <= req_addr;
            data_wdata <= cpu_wdata;
        end
    end

    // Read word capture; stores leave the last loaded word in place
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata <= '0;
        end else if (latch_rdata) begin
            cpu_rdata <= data_rdata;
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb/tb_data_sram_bridge.sv - self-checking bench for data_sram_bridge
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_flush;
    logic        pipe_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          addr_wait;
        int          data_wait;
        int          pstall;
        bit          flush;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    vec_t        vecs[12];
    req_t        req_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    data_sram_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_en       (cpu_en),
        .cpu_wen      (cpu_wen),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_flush    (cpu_flush),
        .pipe_stall   (pipe_stall),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_access(input vec_t v);
        req_t        r;
        req_t        e;
        logic [31:0] er;
        // IDLE cycle: request presented
        @(negedge clk);
        cpu_en       = 1'b1;
        cpu_wen      = v.wen;
        cpu_addr     = v.addr;
        cpu_wdata    = v.wdata;
        cpu_flush    = 1'b0;
        pipe_stall   = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        #1;
        check("idle_stall", cpu_stall, 1);
        check("idle_req", data_req, 0);
        r.wr = v.exp_wr; r.size = v.exp_size; r.addr = v.exp_addr; r.wdata = v.wdata;
        req_q.push_back(r);
        // ADDR cycles: core inputs scrambled to prove the bus fields are held
        for (int k = 0; k <= v.addr_wait; k++) begin
            @(negedge clk);
            cpu_wen      = ~v.wen;
            cpu_addr     = ~v.addr;
            cpu_wdata    = ~v.wdata;
            cpu_flush    = v.flush && (k == 0);
            if (v.flush) cpu_en = 1'b0;
            data_addr_ok = (k == v.addr_wait);
            data_data_ok = (k == 2) && (k < v.addr_wait);
            data_rdata   = 32'hBADBAD00;
            #1;
            check("addr_req", data_req, 1);
            check("addr_stall", cpu_stall, 1);
            e = req_q[0];
            if (k == v.addr_wait) void'(req_q.pop_front());
            check("bus_wr", data_wr, e.wr);
            check("bus_size", data_size, e.size);
            check("bus_addr", data_addr, e.addr);
            check("bus_wdata", data_wdata, e.wdata);
        end
        // DATA cycles
        for (int j = 0; j <= v.data_wait; j++) begin
            @(negedge clk);
            data_addr_ok = 1'b0;
            cpu_flush    = 1'b0;
            data_data_ok = (j == v.data_wait);
            data_rdata   = (j == v.data_wait) ? v.rdata : 32'h0BAD0BAD;
            #1;
            check("data_req", data_req, 0);
            check("data_stall", cpu_stall, v.flush ? 0 : 1);
        end
        if (v.flush) return;
        if (!v.exp_wr) exp_rdata = v.rdata;
        rd_q.push_back(exp_rdata);
        // DONE cycles, held by pipe_stall
        er = rd_q.pop_front();
        for (int p = 0; p <= v.pstall; p++) begin
            @(negedge clk);
            data_data_ok = 1'b0;
            data_rdata   = 32'hFFFF0000 ^ p;
            pipe_stall   = (p < v.pstall);
            cpu_en       = (p < v.pstall);
            cpu_wen      = 4'b0000;
            #1;
            check("done_stall", cpu_stall, 0);
            check("done_rdata", cpu_rdata, er);
            check("done_req", data_req, 0);
        end
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 32'h80001004, 32'h00000000, 32'hDEADBEEF, 0, 0, 0, 1'b0, 1'b0, 2'd2, 32'h80001004};
        vecs[1]  = '{4'b0100, 32'h80000006, 32'h00AB0000, 32'h55555555, 0, 0, 0, 1'b0, 1'b1, 2'd0, 32'h80000006};
        vecs[2]  = '{4'b0011, 32'h80000100, 32'h56785678, 32'h66666666, 5, 0, 0, 1'b0, 1'b1, 2'd1, 32'h80000100};
        vecs[3]  = '{4'b0000, 32'h80000007, 32'h00000000, 32'h12345678, 0, 0, 3, 1'b0, 1'b0, 2'd2, 32'h80000004};
        vecs[4]  = '{4'b1111, 32'h80000013, 32'hA5A5C3C3, 32'h77777777, 1, 0, 0, 1'b0, 1'b1, 2'd2, 32'h80000010};
        vecs[5]  = '{4'b1100, 32'h80000022, 32'hBEEF0000, 32'h88888888, 0, 1, 0, 1'b0, 1'b1, 2'd1, 32'h80000022};
        vecs[6]  = '{4'b0101, 32'h80000031, 32'h11223344, 32'h99999999, 0, 0, 0, 1'b0, 1'b1, 2'd2, 32'h80000030};
        vecs[7]  = '{4'b1000, 32'h80000043, 32'hEE000000, 32'hAAAAAAAA, 0, 2, 0, 1'b0, 1'b1, 2'd0, 32'h80000043};
        vecs[8]  = '{4'b0010, 32'h80000041, 32'h0000DD00, 32'hBBBBBBBB, 0, 0, 0, 1'b0, 1'b1, 2'd0, 32'h80000041};
        vecs[9]  = '{4'b0001, 32'h80000040, 32'h000000CC, 32'hCCCCCCCC, 0, 0, 0, 1'b0, 1'b1, 2'd0, 32'h80000040};
        vecs[10] = '{4'b0011, 32'h80000050, 32'h00009999, 32'hDDDDDDDD, 2, 0, 0, 1'b1, 1'b1, 2'd1, 32'h80000050};
        vecs[11] = '{4'b0000, 32'h80000061, 32'h00000000, 32'hCAFEF00D, 0, 0, 1, 1'b0, 1'b0, 2'd2, 32'h80000060};

        rst          = 1'b1;
        cpu_en       = 1'b1;
        cpu_wen      = 4'b0000;
        cpu_addr     = 32'h80000000;
        cpu_wdata    = 32'h0;
        cpu_flush    = 1'b0;
        pipe_stall   = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        exp_rdata    = 32'h0;

        // Reset state, with a request pending so the stall override is visible
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", cpu_stall, 0);
        check("rst_req", data_req, 0);
        check("rst_wr", data_wr, 0);
        check("rst_size", data_size, 0);
        check("rst_addr", data_addr, 0);
        check("rst_wdata", data_wdata, 0);
        check("rst_rdata", cpu_rdata, 0);
        rst    = 1'b0;
        cpu_en = 1'b0;

        // Flush in IDLE issues nothing
        @(negedge clk);
        cpu_en = 1'b1; cpu_flush = 1'b1; cpu_wen = 4'b1111;
        #1;
        check("flush_idle_stall", cpu_stall, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_en = 1'b0; cpu_flush = 1'b0;
            #1;
            check("flush_idle_req", data_req, 0);
            check("flush_idle_stall2", cpu_stall, 0);
        end

        // Table of accesses, run back to back
        for (int i = 0; i < 12; i++) begin
            run_access(vecs[i]);
        end

        // Reset in the middle of a transaction abandons it
        @(negedge clk);
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h80000070; pipe_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_req_before", data_req, 1);
        @(negedge clk);
        rst = 1'b1; cpu_en = 1'b0;
        #1;
        check("midrst_stall", cpu_stall, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_req", data_req, 0);
        check("midrst_addr", data_addr, 0);
        check("midrst_rdata", cpu_rdata, 0);
        check("midrst_stall2", cpu_stall, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Memory-side counterpart of the MEM-stage load/store formatter.
- Takes the MEM stage's access request (enable, byte-enable strobe, address, store data) and issues exactly one sram-like bus transaction per access.
- Stalls the pipeline until the transaction completes, then holds the raw 32-bit read word on cpu_rdata for the MEM stage to extract bytes/halfwords.
- Sits between the CPU core and the sram-like-to-AXI converter.

Parameters:
ADDR_W, 32, address width on both sides
DATA_W, 32, data width; only 32 is supported

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
cpu_en  in  1  MEM stage has a load or store this cycle
cpu_wen  in  4  byte strobe; 0000 means load, otherwise store
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  store data, already lane-replicated by the core
cpu_flush  in  1  exception/eret in MEM; cancel a not-yet-issued access
pipe_stall  in  1  another stage is stalling; hold the result
cpu_rdata  out  DATA_W  raw read word, valid while cpu_stall=0 after a load
cpu_stall  out  1  access in flight
data_req  out  1  sram-like request
data_wr  out  1  1 = write
data_size  out  2  0 = byte, 1 = half, 2 = word
data_addr  out  ADDR_W  bus address
data_wdata  out  DATA_W  bus write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  data phase done; rdata valid for reads
data_rdata  in  DATA_W  read data

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE.
  - data_req, data_wr, data_size, data_addr, data_wdata, cpu_rdata all 0.
  - cancel flag cleared.
  - cpu_stall is forced to 0 while rst=1.
- A reset mid-transaction abandons it; the interconnect is reset in the same cycle.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If cpu_en=1 and cpu_flush=0: latch the request into the bus registers and go to ADDR.
  - Otherwise stay in IDLE.
  - cpu_stall = cpu_en & ~cpu_flush.
- Request encoding, latched in IDLE:
  - data_wr = |cpu_wen.
  - Size from cpu_wen:
    - 0001/0010/0100/1000 → size 0, data_addr = cpu_addr.
    - 0011/1100 → size 1, data_addr = cpu_addr.
    - 1111 → size 2, data_addr = {cpu_addr[ADDR_W-1:2], 2'b00}.
    - 0000 (load) → size 2, word-aligned data_addr.
    - Any other nonzero pattern → size 2, word-aligned (not generated by the core).
  - data_wdata = cpu_wdata unchanged.
- ADDR:
  - data_req=1; the request fields are held stable.
  - On data_addr_ok=1 → DATA.
  - data_req is never dropped before addr_ok. A cpu_flush arriving here sets the cancel flag only.
- DATA:
  - data_req=0.
  - On data_data_ok=1: latch cpu_rdata=data_rdata (reads only; writes leave cpu_rdata unchanged), then go to DONE, or to IDLE if the cancel flag is set.
  - data_data_ok is never expected in the same cycle as addr_ok. If it arrives while in ADDR it is ignored, because the bus protocol forbids it.
- DONE:
  - cpu_stall=0 and cpu_rdata stable.
  - If pipe_stall=1, stay; otherwise go to IDLE.
- cpu_stall = 1 in ADDR and DATA. In DATA with the cancel flag set it is 0, since the flushed instruction has already left.
- Minimum latency (addr_ok in the first req cycle, data_ok the next cycle): en seen at cycle 0 → req at cycle 1 → data_ok at cycle 2 → cpu_stall low and cpu_rdata valid at cycle 3.
- A flush in IDLE issues no transaction.
- Back-to-back accesses: DONE→IDLE with pipe_stall=0, then a new request is accepted in the following IDLE cycle. There is no overlap of transactions.
- Exactly one outstanding transaction at any time.

Decomposition:
- Shared package/header holds:
  - SIZE_BYTE, SIZE_HALF, SIZE_WORD constants.
  - FSM state encodings S_IDLE, S_ADDR, S_DATA, S_DONE.
  - The sram-like port bundle widths.
- One natural sub-module, wen_to_size: combinational strobe → {size, aligned address}, reused by the instruction-side bridge for size only.

Test Plan:
- Load word: en=1, wen=0000, addr=0x80001004; addr_ok on the first req cycle, data_ok next with rdata=0xDEADBEEF → req only in cycle 1, size=2, wr=0, stall high cycles 0-2, cpu_rdata=0xDEADBEEF with stall=0 in cycle 3.
- Store byte: wen=0100, addr=0x80000006, wdata=0x00AB0000 → data_wr=1, size=0, data_addr=0x80000006, data_wdata=0x00AB0000; cpu_rdata unchanged.
- Addr backpressure: addr_ok held low for 5 cycles → data_req stays 1 and addr/wdata/size stay constant for all 5 cycles; stall stays 1.
- Flush in ADDR: wen=0011 store issued, cpu_flush=1 while addr_ok=0 → req held until addr_ok, transaction completes, stall drops to 0 in DATA, FSM returns to IDLE without entering DONE.
- Flush in IDLE: en=1, flush=1 → no data_req ever asserted, cpu_stall=0.
- Hold on pipe_stall: load completes with rdata=0x12345678 while pipe_stall=1 for 3 cycles → FSM stays in DONE, cpu_rdata=0x12345678 stable, no new req. Then pipe_stall=0 → IDLE; the next access's req appears 1 cycle after the following IDLE cycle.
